// File: rtl/split_two.sv
// split_two: clocked 1-to-2 four-phase packet demultiplexer.
// Ports: clk, rst (async, active high); in_req/in_ack/in_data input channel;
//   out0_req/out0_ack/out0_data and out1_req/out1_ack/out1_data output
//   channels; busy is high whenever the FSM is not idle.
// Optional: define SPLIT_TWO_BCAST_EN so that a packet whose 2-bit field at
//   BCAST_LSB is 2'b11 is sent to both outputs.
module split_two #(
    parameter int WIDTH     = 35,
    parameter int ROUTE_BIT = 34,
    parameter int FL        = 2,
    parameter int BCAST_LSB = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_req,
    output logic             in_ack,
    input  logic [WIDTH-1:0] in_data,
    output logic             out0_req,
    input  logic             out0_ack,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_req,
    input  logic             out1_ack,
    output logic [WIDTH-1:0] out1_data,
    output logic             busy
);

    localparam int CW = (FL > 0) ? $clog2(FL + 1) : 1;
    localparam logic [CW-1:0] CLOAD = CW'((FL > 0) ? FL - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
        IN_RTZ,
        DELAY,
        OUT_REQ,
        OUT_RTZ
    } state_t;

    state_t            state, state_n;
    logic [WIDTH-1:0]  pkt, pkt_n;
    logic              sel, sel_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic              in_ack_n;
    logic              out0_req_n, out1_req_n;
    logic [WIDTH-1:0]  out0_data_n, out1_data_n;
    logic              enter_out;
    logic              go0, go1;
    logic              ack0_ok, ack1_ok;
    logic              rtz0_ok, rtz1_ok;

`ifdef SPLIT_TWO_BCAST_EN
    logic bc, bc_n;
    logic done0, done0_n;
    logic done1, done1_n;

    assign go0 = bc | ~sel;
    assign go1 = bc | sel;
    // A channel not taking part in this packet counts as already done.
    assign ack0_ok = ~go0 | done0 | out0_ack;
    assign ack1_ok = ~go1 | done1 | out1_ack;
`else
    assign go0 = ~sel;
    assign go1 = sel;
    assign ack0_ok = go0 & out0_ack;
    assign ack1_ok = go1 & out1_ack;
`endif

    assign rtz0_ok = ~go0 | ~out0_ack;
    assign rtz1_ok = ~go1 | ~out1_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pkt       <= '0;
            sel       <= 1'b0;
            cnt       <= '0;
            in_ack    <= 1'b0;
            out0_req  <= 1'b0;
            out1_req  <= 1'b0;
            out0_data <= '0;
            out1_data <= '0;
            busy      <= 1'b0;
`ifdef SPLIT_TWO_BCAST_EN
            bc        <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            pkt       <= pkt_n;
            sel       <= sel_n;
            cnt       <= cnt_n;
            in_ack    <= in_ack_n;
            out0_req  <= out0_req_n;
            out1_req  <= out1_req_n;
            out0_data <= out0_data_n;
            out1_data <= out1_data_n;
            busy      <= (state_n != IDLE);
`ifdef SPLIT_TWO_BCAST_EN
            bc        <= bc_n;
            done0     <= done0_n;
            done1     <= done1_n;
`endif
        end
    end

    always_comb begin
        state_n     = state;
        pkt_n       = pkt;
        sel_n       = sel;
        cnt_n       = cnt;
        in_ack_n    = in_ack;
        out0_req_n  = out0_req;
        out1_req_n  = out1_req;
        out0_data_n = out0_data;
        out1_data_n = out1_data;
        enter_out   = 1'b0;
`ifdef SPLIT_TWO_BCAST_EN
        bc_n        = bc;
        done0_n     = done0;
        done1_n     = done1;
`endif
        unique case (state)
            IDLE: begin
`ifdef SPLIT_TWO_BCAST_EN
                done0_n = 1'b0;
                done1_n = 1'b0;
`endif
                if (in_req) begin
                    pkt_n    = in_data;
                    sel_n    = in_data[ROUTE_BIT];
                    in_ack_n = 1'b1;
                    state_n  = IN_RTZ;
`ifdef SPLIT_TWO_BCAST_EN
                    bc_n = (in_data[BCAST_LSB+1:BCAST_LSB] == 2'b11);
`endif
                end
            end
            IN_RTZ: begin
                if (!in_req) begin
                    in_ack_n = 1'b0;
                    if (FL == 0) begin
                        enter_out = 1'b1;
                    end else begin
                        cnt_n   = CLOAD;
                        state_n = DELAY;
                    end
                end
            end
            DELAY: begin
                if (cnt == '0) begin
                    enter_out = 1'b1;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            OUT_REQ: begin
`ifdef SPLIT_TWO_BCAST_EN
                if (go0 && out0_ack) begin
                    out0_req_n = 1'b0;
                    done0_n    = 1'b1;
                end
                if (go1 && out1_ack) begin
                    out1_req_n = 1'b0;
                    done1_n    = 1'b1;
                end
                if (ack0_ok && ack1_ok) begin
                    state_n = OUT_RTZ;
                end
`else
                if (ack0_ok) begin
                    out0_req_n = 1'b0;
                    state_n    = OUT_RTZ;
                end
                if (ack1_ok) begin
                    out1_req_n = 1'b0;
                    state_n    = OUT_RTZ;
                end
`endif
            end
            OUT_RTZ: begin
                if (rtz0_ok && rtz1_ok) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Request and data are registered on the same edge the FSM
        // enters OUT_REQ, so the unselected channel is never touched.
        if (enter_out) begin
            state_n = OUT_REQ;
            if (go0) begin
                out0_req_n  = 1'b1;
                out0_data_n = pkt;
            end
            if (go1) begin
                out1_req_n  = 1'b1;
                out1_data_n = pkt;
            end
        end
    end

endmodule

// File: tb/tb_split_two.sv
// tb_split_two: directed self-checking bench for split_two.
// Instance a uses FL=2, instance b uses FL=0.
module tb_split_two;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        a_in_req = 1'b0, a_in_ack;
    logic [34:0] a_in_data = '0;
    logic        a_o0_req, a_o0_ack = 1'b0;
    logic [34:0] a_o0_data;
    logic        a_o1_req, a_o1_ack = 1'b0;
    logic [34:0] a_o1_data;
    logic        a_busy;

    logic        b_in_req = 1'b0, b_in_ack;
    logic [34:0] b_in_data = '0;
    logic        b_o0_req, b_o0_ack = 1'b0;
    logic [34:0] b_o0_data;
    logic        b_o1_req, b_o1_ack = 1'b0;
    logic [34:0] b_o1_data;
    logic        b_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    split_two #(.WIDTH(35), .ROUTE_BIT(34), .FL(2), .BCAST_LSB(32)) u_a (
        .clk(clk), .rst(rst),
        .in_req(a_in_req), .in_ack(a_in_ack), .in_data(a_in_data),
        .out0_req(a_o0_req), .out0_ack(a_o0_ack), .out0_data(a_o0_data),
        .out1_req(a_o1_req), .out1_ack(a_o1_ack), .out1_data(a_o1_data),
        .busy(a_busy)
    );

    split_two #(.WIDTH(35), .ROUTE_BIT(34), .FL(0), .BCAST_LSB(32)) u_b (
        .clk(clk), .rst(rst),
        .in_req(b_in_req), .in_ack(b_in_ack), .in_data(b_in_data),
        .out0_req(b_o0_req), .out0_ack(b_o0_ack), .out0_data(b_o0_data),
        .out1_req(b_o1_req), .out1_ack(b_o1_ack), .out1_data(b_o1_data),
        .busy(b_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset state
        tick(); tick();
        chk("rst_a", {a_in_ack, a_o0_req, a_o1_req, a_busy}, 4'b0000);
        chk("rst_a_data", {a_o0_data, a_o1_data}, 70'h0);
        chk("rst_b", {b_in_ack, b_o0_req, b_o1_req, b_busy}, 4'b0000);
        rst = 1'b0;
        tick();

        // FL=2, route to out1
        a_in_data = 35'h4_0000_00AB;
        a_in_req  = 1'b1;
        tick();
        chk("a_ack_rise", {a_in_ack, a_busy}, 2'b11);
        a_in_req = 1'b0;
        tick();
        chk("a_ack_fall", {a_in_ack, a_o1_req}, 2'b00);
        tick();
        chk("a_delay", {a_o0_req, a_o1_req}, 2'b00);
        tick();
        chk("a_o1_req", {a_o0_req, a_o1_req}, 2'b01);
        chk("a_o1_data", a_o1_data, 35'h4_0000_00AB);
        chk("a_o0_data", a_o0_data, 35'h0);
        a_o1_ack = 1'b1;
        tick();
        chk("a_o1_clr", {a_o1_req, a_busy}, 2'b01);
        chk("a_o1_hold", a_o1_data, 35'h4_0000_00AB);
        a_o1_ack = 1'b0;
        tick();
        chk("a_idle", a_busy, 1'b0);

        // reset in the middle of OUT_REQ on out1
        a_in_data = 35'h4_0000_0077;
        a_in_req  = 1'b1;
        tick();
        a_in_req = 1'b0;
        tick(); tick(); tick();
        chk("a_pre_rst", a_o1_req, 1'b1);
        rst = 1'b1;
        #1;
        chk("a_async_rst", {a_in_ack, a_o1_req, a_busy}, 3'b000);
        chk("a_rst_data", a_o1_data, 35'h0);
        tick();
        rst = 1'b0;
        tick();
        chk("a_post_rst", {a_o0_req, a_o1_req, a_busy}, 3'b000);
        a_in_data = 35'h0_0000_0055;
        a_in_req  = 1'b1;
        tick();
        chk("a_pr_ack", a_in_ack, 1'b1);
        a_in_req = 1'b0;
        tick(); tick(); tick();
        chk("a_pr_route", {a_o0_req, a_o1_req}, 2'b10);
        chk("a_pr_data", a_o0_data, 35'h0_0000_0055);
        a_o0_ack = 1'b1;
        tick();
        a_o0_ack = 1'b0;
        tick();
        chk("a_pr_idle", a_busy, 1'b0);

        // FL=0, route to out0 with a stalled ack
        b_in_data = 35'h0_1234_5678;
        b_in_req  = 1'b1;
        tick();
        chk("b_ack_rise", b_in_ack, 1'b1);
        b_in_req = 1'b0;
        tick();
        chk("b_o0_req", {b_in_ack, b_o0_req, b_o1_req}, 3'b010);
        chk("b_o0_data", b_o0_data, 35'h0_1234_5678);
        b_in_data = 35'h4_0000_0001;
        b_in_req  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("b_stall", {b_o0_req, b_in_ack}, 2'b10);
        end
        b_o0_ack = 1'b1;
        tick();
        chk("b_o0_clr", {b_o0_req, b_in_ack, b_busy}, 3'b001);
        b_o1_ack = 1'b1;
        tick();
        chk("b_wait_rtz", b_in_ack, 1'b0);
        b_o0_ack = 1'b0;
        tick();
        chk("b_back_idle", {b_in_ack, b_busy}, 2'b00);
        tick();
        chk("b_ack2", b_in_ack, 1'b1);
        b_in_req = 1'b0;
        tick();
        chk("b_o1_req", {b_o0_req, b_o1_req}, 2'b01);
        chk("b_o1_data", b_o1_data, 35'h4_0000_0001);
        tick();
        chk("b_o1_early", {b_o1_req, b_busy}, 2'b01);
        chk("b_o0_keep", {b_o0_req, b_o0_data}, {1'b0, 35'h0_1234_5678});
        b_o1_ack = 1'b0;
        tick();
        chk("b_idle2", b_busy, 1'b0);

`ifdef SPLIT_TWO_BCAST_EN
        // broadcast on instance a
        a_in_data = 35'h3_0000_0012;
        a_in_req  = 1'b1;
        tick();
        a_in_req = 1'b0;
        tick(); tick(); tick();
        chk("bc_both", {a_o0_req, a_o1_req}, 2'b11);
        chk("bc_data", {a_o0_data, a_o1_data},
            {35'h3_0000_0012, 35'h3_0000_0012});
        a_o0_ack = 1'b1;
        tick();
        chk("bc_o0_clr", {a_o0_req, a_o1_req, a_busy}, 3'b011);
        tick();
        a_o0_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bc_wait", {a_o1_req, a_busy}, 2'b11);
        end
        a_o1_ack = 1'b1;
        tick();
        chk("bc_o1_clr", {a_o1_req, a_busy}, 2'b01);
        a_o1_ack = 1'b0;
        tick();
        chk("bc_idle", a_busy, 1'b0);
`else
        // broadcast code is plain payload here
        a_in_data = 35'h3_0000_0012;
        a_in_req  = 1'b1;
        tick();
        a_in_req = 1'b0;
        tick(); tick(); tick();
        chk("nobc_route", {a_o0_req, a_o1_req}, 2'b10);
        chk("nobc_data", a_o0_data, 35'h3_0000_0012);
        a_o0_ack = 1'b1;
        tick();
        a_o0_ack = 1'b0;
        tick();
        chk("nobc_idle", {a_o1_req, a_busy}, 2'b00);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/split_two.md
Name: split_two

Overview:
- Clocked 1-to-2 packet demultiplexer. It is the fan-out counterpart of the NoC router's two-input arbiter/merge.
- Accepts one packet on a four-phase req/ack input channel and steers it to exactly one of two four-phase output channels, chosen by a route bit inside the packet.
- Sits at router inputs, where it splits the traffic that a downstream merge recombines.

Parameters:
- WIDTH, 35, packet width in bits.
- ROUTE_BIT, 34, index of the packet bit that selects the output (0 -> out0, 1 -> out1).
- FL, 2, forward latency: clock cycles inserted between input handshake completion and output req assertion. 0 is legal.
- BCAST_LSB, 32, low index of the 2-bit broadcast code field. Used only with the optional feature.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_req  in  1  input channel request.
- in_ack  out  1  input channel acknowledge.
- in_data  in  WIDTH  input packet; stable while in_req=1.
- out0_req  out  1  output 0 request.
- out0_ack  in  1  output 0 acknowledge.
- out0_data  out  WIDTH  output 0 packet.
- out1_req  out  1  output 1 request.
- out1_ack  in  1  output 1 acknowledge.
- out1_data  out  WIDTH  output 1 packet.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; in_ack, out0_req, out1_req and busy = 0.
  - out0_data, out1_data, packet register and delay counter = 0.
  - Reset mid-transfer aborts the packet silently; all reqs and acks drop immediately. No replay.
- All outputs are registered. Every input is sampled once per rising edge.
- State machine, one packet at a time, no overlap:
  - IDLE: when in_req=1 is sampled, latch in_data into the packet register, latch sel=in_data[ROUTE_BIT], set in_ack=1, go to IN_RTZ.
  - IN_RTZ: hold in_ack=1 until in_req=0 is sampled, then set in_ack=0.
    - FL=0: go to OUT_REQ.
    - FL>0: load counter with FL-1 and go to DELAY.
  - DELAY: decrement the counter each cycle; when the counter is 0, go to OUT_REQ.
  - OUT_REQ:
    - On entry, drive out<sel>_data = packet and out<sel>_req=1. The other channel's req and data are untouched.
    - When out<sel>_ack=1 is sampled, clear out<sel>_req and go to OUT_RTZ.
    - Data holds its value after req falls.
  - OUT_RTZ: when out<sel>_ack=0 is sampled, go to IDLE.
- Latency: in_req rise -> in_ack rise is 1 cycle. in_req fall -> out req rise is FL+1 cycles. Input throughput is bounded by full output round-trip completion.
- in_ack never rises while state != IDLE, so a new in_req waits. This is the only form of backpressure.
- An out_ack that is already high on entry to OUT_REQ is treated as that cycle's acknowledge. Protocol compliance is the peer's responsibility; no error flagging.
- Acks on the unselected channel are ignored.
- Counter width is $clog2(FL+1), minimum 1.

Optional Feature:
- Macro SPLIT_TWO_BCAST_EN.
- With the macro defined:
  - If packet[BCAST_LSB+1:BCAST_LSB] == 2'b11, the packet is broadcast and ROUTE_BIT is ignored.
  - OUT_REQ raises out0_req and out1_req together with identical data.
  - Each req clears independently on its own ack.
  - OUT_RTZ is entered only after both acks have been seen. IDLE is entered only after both acks are sampled 0.
  - Sticky done0/done1 flags track this and clear in IDLE.
- Without the macro: the field is ordinary payload and routing uses ROUTE_BIT only. No done flags are synthesized.

Test Plan:
- Reset mid-OUT_REQ (out1_req=1): assert rst -> out1_req, in_ack and busy drop asynchronously; after release, state is IDLE and the next packet routes normally.
- FL=2, in_data=35'h4_0000_00AB (bit34=1): in_ack rises 1 cycle after in_req; out1_req rises 3 cycles after in_req falls with out1_data=35'h4_0000_00AB; out0_req stays 0.
- FL=0, in_data=35'h0_1234_5678 (bit34=0): out0_req rises 1 cycle after in_req falls with out0_data=35'h0_1234_5678; out0_ack held 0 for 10 cycles -> out0_req stays 1 and in_ack stays 0 while a second in_req is pending.
- Back-to-back packets to out0 then out1 with out1_ack tied high early: second in_ack does not rise until out0_ack returns to 0; each packet appears only on its selected channel.
- SPLIT_TWO_BCAST_EN, in_data bits[33:32]=2'b11: both reqs rise in the same cycle; out0_ack returns after 2 cycles, out1_ack after 7; busy stays high until both acks are back to 0.
- Without SPLIT_TWO_BCAST_EN, same packet with bit34=0: only out0_req rises.
